// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the framed program-image loader.
package prog_loader_pkg;

    localparam int                DEF_ADDR_W = 4;
    localparam int                DEF_DATA_W = 8;
    localparam int                MEM_DEPTH  = 1 << DEF_ADDR_W;
    localparam logic [7:0]        DEF_SYNC   = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream loader: SYNC, LEN, data, XOR csum -> memory writes, cpu_run on good image.
// Write latency 1 cycle after acceptance; in_ready is held high outside reset, so the stream never stalls.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int                  ADDR_W = DEF_ADDR_W,
    parameter int                  DATA_W = DEF_DATA_W,
    parameter logic [DATA_W-1:0]   SYNC   = DATA_W'(DEF_SYNC)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [DATA_W-1:0]   in_data_i,
    input  logic                abort_i,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic                cpu_run_o,
    output logic                load_err_o,
    output logic                load_busy_o,
    output logic [ADDR_W:0]     bytes_loaded_o
);

    localparam int DEPTH = 1 << ADDR_W;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   csum_q, csum_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic                rdy_q;

    logic                accept;
    logic                is_sync;
    logic                len_valid;
    logic [ADDR_W:0]     cnt_inc;

    assign accept    = in_valid_i && rdy_q;
    assign is_sync   = (in_data_i == SYNC);
    assign len_valid = (in_data_i != '0) && (int'(in_data_i) <= DEPTH);
    assign cnt_inc   = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;

        // abort wins over a byte arriving on the same edge; that byte is lost
        if (abort_i) begin
            state_d = ST_IDLE;
        end else if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_sync) state_d = ST_LEN;
                end
                ST_LEN: begin
                    if (len_valid) begin
                        len_d   = in_data_i[ADDR_W:0];
                        cnt_d   = '0;
                        csum_d  = '0;
                        state_d = ST_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
                ST_DATA: begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = in_data_i;
                    cnt_d   = cnt_inc;
                    csum_d  = csum_q ^ in_data_i;
                    if (cnt_inc == len_q) state_d = ST_CSUM;
                end
                ST_CSUM: begin
                    if (in_data_i == csum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
                ST_DONE: begin
                    if (is_sync) state_d = ST_LEN;
                end
                ST_ERR: begin
                    if (is_sync) begin
                        err_d   = 1'b0;
                        state_d = ST_LEN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdy_q   <= 1'b1;
        end
    end

    assign in_ready_o     = rdy_q;
    assign mem_we_o       = we_q;
    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = wdata_q;
    assign cpu_run_o      = (state_q == ST_DONE);
    assign load_err_o     = err_q;
    assign load_busy_o    = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign bytes_loaded_o = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framed loads, checksum/length errors, reload, abort and async reset.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       abort;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_run;
    logic       load_err;
    logic       load_busy;
    logic [4:0] bytes_loaded;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int wr_base;
    logic [7:0] tb_mem [16];

    always #5 clk = ~clk;

    prog_loader dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_data_i      (in_data),
        .abort_i        (abort),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .cpu_run_o      (cpu_run),
        .load_err_o     (load_err),
        .load_busy_o    (load_busy),
        .bytes_loaded_o (bytes_loaded)
    );

    // write monitor: one sample per cycle, away from the active edge
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_cnt++;
            tb_mem[mem_addr] = mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_abort(input logic with_byte, input logic [7:0] b);
        @(negedge clk);
        abort    = 1'b1;
        in_valid = with_byte;
        in_data  = b;
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        abort    = 1'b0;
        for (int i = 0; i < 16; i++) tb_mem[i] = 8'h00;

        // reset values
        #3;
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_run", cpu_run, 0);
        check("rst_load_err", load_err, 0);
        check("rst_load_busy", load_busy, 0);
        check("rst_bytes", bytes_loaded, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", in_ready, 1);

        // good 3-byte frame, csum 11^22^44 = 77
        wr_base = wr_cnt;
        send(8'hA5);
        check("A_busy_len", load_busy, 1);
        send(8'h03);
        send(8'h11);
        check("A_we0", mem_we, 1);
        check("A_addr0", mem_addr, 0);
        check("A_data0", mem_wdata, 8'h11);
        send(8'h22);
        check("A_addr1", mem_addr, 1);
        check("A_data1", mem_wdata, 8'h22);
        send(8'h44);
        check("A_addr2", mem_addr, 2);
        check("A_data2", mem_wdata, 8'h44);
        send(8'h77);
        check("A_we_after_csum", mem_we, 0);
        check("A_cpu_run", cpu_run, 1);
        check("A_bytes", bytes_loaded, 3);
        check("A_err", load_err, 0);
        check("A_busy", load_busy, 0);
        check("A_writes", wr_cnt - wr_base, 3);

        // bad checksum from DONE: A5 02 10 20 31 (correct would be 30)
        wr_base = wr_cnt;
        send(8'hA5);
        check("B_run_drops_on_sync", cpu_run, 0);
        send(8'h02);
        send(8'h10);
        send(8'h20);
        send(8'h31);
        check("B_err", load_err, 1);
        check("B_run", cpu_run, 0);
        check("B_busy", load_busy, 0);
        check("B_writes", wr_cnt - wr_base, 2);
        send(8'hA5);
        check("B_err_cleared", load_err, 0);
        send(8'h01);
        send(8'h5A);
        send(8'h5A);
        check("B_run_after_reload", cpu_run, 1);
        check("B_bytes", bytes_loaded, 1);
        check("B_mem0", tb_mem[0], 8'h5A);

        // illegal lengths 0 and 17
        wr_base = wr_cnt;
        send(8'hA5);
        send(8'h00);
        check("L0_err", load_err, 1);
        check("L0_busy", load_busy, 0);
        check("L0_run", cpu_run, 0);
        send(8'hA5);
        send(8'h11);
        check("L17_err", load_err, 1);
        check("L17_busy", load_busy, 0);
        check("L_writes", wr_cnt - wr_base, 0);

        // recover, then full 16-byte reload from DONE (xor of 00..0F is 00)
        send(8'hA5);
        send(8'h01);
        send(8'h3C);
        send(8'h3C);
        check("F_pre_run", cpu_run, 1);
        wr_base = wr_cnt;
        send(8'hA5);
        check("F_run_drops", cpu_run, 0);
        send(8'h10);
        for (int i = 0; i < 16; i++) send(8'(i));
        check("F_last_addr", mem_addr, 15);
        send(8'h00);
        check("F_run", cpu_run, 1);
        check("F_bytes", bytes_loaded, 16);
        check("F_writes", wr_cnt - wr_base, 16);
        check("F_mem7", tb_mem[7], 8'h07);
        check("F_mem15", tb_mem[15], 8'h0F);

        // abort from DONE, garbage in IDLE, then a normal frame
        pulse_abort(1'b0, 8'h00);
        check("G_abort_run", cpu_run, 0);
        check("G_abort_busy", load_busy, 0);
        wr_base = wr_cnt;
        send(8'h00);
        send(8'hFF);
        send(8'h3C);
        check("G_garbage_busy", load_busy, 0);
        check("G_garbage_writes", wr_cnt - wr_base, 0);
        send(8'hA5);
        send(8'h02);
        send(8'hAA);
        send(8'hBB);
        send(8'h11);
        check("G_run", cpu_run, 1);
        check("G_mem0", tb_mem[0], 8'hAA);
        check("G_mem1", tb_mem[1], 8'hBB);
        check("G_writes", wr_cnt - wr_base, 2);

        // async reset mid-DATA, then a full frame (01^02^04^08 = 0F)
        send(8'hA5);
        send(8'h04);
        send(8'h01);
        send(8'h02);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("R_in_ready", in_ready, 0);
        check("R_mem_we", mem_we, 0);
        check("R_mem_addr", mem_addr, 0);
        check("R_mem_wdata", mem_wdata, 0);
        check("R_busy", load_busy, 0);
        check("R_bytes", bytes_loaded, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wr_base = wr_cnt;
        send(8'hA5);
        send(8'h04);
        send(8'h01);
        send(8'h02);
        send(8'h04);
        send(8'h08);
        send(8'h0F);
        check("R_run", cpu_run, 1);
        check("R_bytes_after", bytes_loaded, 4);
        check("R_writes", wr_cnt - wr_base, 4);
        check("R_mem3", tb_mem[3], 8'h08);

        // abort in CSUM with the correct csum byte on the same edge
        send(8'hA5);
        send(8'h01);
        send(8'h77);
        check("X_busy_csum", load_busy, 1);
        pulse_abort(1'b1, 8'h77);
        check("X_run", cpu_run, 0);
        check("X_busy", load_busy, 0);
        check("X_err", load_err, 0);
        send(8'h77);
        check("X_run_idle", cpu_run, 0);

        // abort while in ERR keeps the sticky error
        send(8'hA5);
        send(8'h00);
        check("E_err", load_err, 1);
        pulse_abort(1'b0, 8'h00);
        check("E_err_kept", load_err, 1);
        check("E_busy", load_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
